// File: rtl/signed_seq_divider.sv
// Signed sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, truncating toward zero.
// Optional macro DIV_ZERO_DETECT_EN adds a divide-by-zero fast path and the dz flag.
module signed_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               dz
);

  localparam int DW = 2 * WIDTH;
  localparam int MW = DW + 1;
  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Magnitude of the most negative dividend, only reachable from -2^(DW-1).
  localparam logic [MW-1:0] MIN_MAG   = {2'b01, {(DW-1){1'b0}}};
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic [MW-1:0]    rem_q, rem_d;
  logic [MW-1:0]    dsr_mag_q, dsr_mag_d;
  logic             sign_diff_q, sign_diff_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [DW-1:0]    quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] dvd_lo_q, dvd_lo_d;
  logic             dz_q, dz_d;
`endif

  logic [MW-1:0]    dvd_ext, dvd_mag;
  logic [MW-1:0]    dsr_ext, dsr_mag;
  logic [MW:0]      rem_sh;
  logic             step_ge;
  logic [MW-1:0]    rem_step;
  logic [DW-1:0]    quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign dvd_ext = {dividend[DW-1], dividend};
  assign dvd_mag = dividend[DW-1] ? -dvd_ext : dvd_ext;
  assign dsr_ext = {{(MW-WIDTH){divisor[WIDTH-1]}}, divisor};
  assign dsr_mag = divisor[WIDTH-1] ? -dsr_ext : dsr_ext;

  // One restoring step: the dividend bits shift out of dq_q's top while quotient bits enter its bottom.
  assign rem_sh   = {rem_q, dq_q[DW-1]};
  assign step_ge  = (rem_sh >= {1'b0, dsr_mag_q});
  assign rem_step = step_ge ? MW'(rem_sh - {1'b0, dsr_mag_q}) : rem_sh[MW-1:0];

  assign quot_fix = sign_diff_q ? -dq_q : dq_q;
  assign rem_fix  = dvd_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dsr_mag_d   = dsr_mag_q;
    sign_diff_d = sign_diff_q;
    dvd_neg_d   = dvd_neg_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dz_pend_d   = dz_pend_q;
    dvd_lo_d    = dvd_lo_q;
    dz_d        = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dq_d        = dvd_mag[DW-1:0];
          rem_d       = '0;
          dsr_mag_d   = dsr_mag;
          sign_diff_d = dividend[DW-1] ^ divisor[WIDTH-1];
          dvd_neg_d   = dividend[DW-1];
          ovf_pend_d  = dividend[DW-1] && (dvd_mag == MIN_MAG) && (divisor == '1);
          cnt_d       = '0;
          state_d     = RUN;
`ifdef DIV_ZERO_DETECT_EN
          dz_pend_d   = (divisor == '0);
          dvd_lo_d    = dividend[WIDTH-1:0];
          if (divisor == '0) begin
            state_d = FIX;
          end
`endif
        end
      end
      RUN: begin
        dq_d  = {dq_q[DW-2:0], step_ge};
        rem_d = rem_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = quot_fix;
        remainder_d = rem_fix;
        ovf_d       = ovf_pend_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d        = dz_pend_q;
        if (dz_pend_q) begin
          quotient_d  = '1;
          remainder_d = dvd_lo_q;
          ovf_d       = 1'b0;
        end
`endif
        state_d = DONE;
      end
      DONE: begin
        // The pulse is registered, so it appears in the cycle the FSM is back in IDLE.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      dsr_mag_q   <= '0;
      sign_diff_q <= 1'b0;
      dvd_neg_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_pend_q   <= 1'b0;
      dvd_lo_q    <= '0;
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dsr_mag_q   <= dsr_mag_d;
      sign_diff_q <= sign_diff_d;
      dvd_neg_q   <= dvd_neg_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_pend_q   <= dz_pend_d;
      dvd_lo_q    <= dvd_lo_d;
      dz_q        <= dz_d;
`endif
    end
  end

  assign busy      = (state_q == RUN) || (state_q == FIX);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
`ifdef DIV_ZERO_DETECT_EN
  assign dz        = dz_q;
`else
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed bench for signed_seq_divider (WIDTH=4): quadrants, extremes, divide-by-zero, handshake, reset.
module tb_signed_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       ovf;
  logic       dz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_edge = 0;

  localparam logic [7:0] QD_A [5] = '{8'd21, 8'd21, 8'hEB, 8'd30, 8'hE1};
  localparam logic [3:0] QD_B [5] = '{4'd7,  4'h9,  4'h9,  4'hA,  4'd6};
  localparam logic [7:0] QD_Q [5] = '{8'h03, 8'hFD, 8'h03, 8'hFB, 8'hFB};
  localparam logic [3:0] QD_R [5] = '{4'h0,  4'h0,  4'h0,  4'h0,  4'hF};

  localparam logic [7:0] EX_A [3] = '{8'h80, 8'h80, 8'h7F};
  localparam logic [3:0] EX_B [3] = '{4'hF,  4'h1,  4'h8};
  localparam logic [7:0] EX_Q [3] = '{8'h80, 8'h80, 8'hF1};
  localparam logic [3:0] EX_R [3] = '{4'h0,  4'h0,  4'h7};
  localparam logic       EX_O [3] = '{1'b1,  1'b0,  1'b0};

  signed_seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one start from IDLE; operands are scrambled right after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    n_edge   = cyc;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - n_edge;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'h5A; divisor = 4'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", quotient); end
    checks++; if (remainder !== 4'h0) begin errors++; $display("FAIL reset_r: got %h expected 0", remainder); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (dz !== 1'b0)        begin errors++; $display("FAIL reset_dz: got %b expected 0", dz); end
    rst = 1'b0;
    $display("reset: outputs q=%h r=%h busy=%b done=%b", quotient, remainder, busy, done);
  endtask

  task automatic test_quadrants();
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(QD_A[i], QD_B[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL quad%0d_busy: got %b expected 1", i, busy); end
      wait_done(lat);
      $display("quad%0d: %h / %h -> q=%h r=%h lat=%0d", i, QD_A[i], QD_B[i], quotient, remainder, lat);
      checks++; if (lat !== 10)            begin errors++; $display("FAIL quad%0d_lat: got %0d expected 10", i, lat); end
      checks++; if (quotient !== QD_Q[i])  begin errors++; $display("FAIL quad%0d_q: got %h expected %h", i, quotient, QD_Q[i]); end
      checks++; if (remainder !== QD_R[i]) begin errors++; $display("FAIL quad%0d_r: got %h expected %h", i, remainder, QD_R[i]); end
      checks++; if (ovf !== 1'b0)          begin errors++; $display("FAIL quad%0d_ovf: got %b expected 0", i, ovf); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL quad%0d_busy_done: got %b expected 0", i, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0)         begin errors++; $display("FAIL quad%0d_pulse: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_extremes();
    int lat;
    for (int i = 0; i < 3; i++) begin
      launch(EX_A[i], EX_B[i]);
      wait_done(lat);
      $display("ext%0d: %h / %h -> q=%h r=%h ovf=%b lat=%0d", i, EX_A[i], EX_B[i], quotient, remainder, ovf, lat);
      checks++; if (lat !== 10)            begin errors++; $display("FAIL ext%0d_lat: got %0d expected 10", i, lat); end
      checks++; if (quotient !== EX_Q[i])  begin errors++; $display("FAIL ext%0d_q: got %h expected %h", i, quotient, EX_Q[i]); end
      checks++; if (remainder !== EX_R[i]) begin errors++; $display("FAIL ext%0d_r: got %h expected %h", i, remainder, EX_R[i]); end
      checks++; if (ovf !== EX_O[i])       begin errors++; $display("FAIL ext%0d_ovf: got %b expected %b", i, ovf, EX_O[i]); end
    end
    repeat (5) @(negedge clk);
    checks++; if (quotient !== 8'hF1)  begin errors++; $display("FAIL ext_hold_q: got %h expected f1", quotient); end
    checks++; if (remainder !== 4'h7)  begin errors++; $display("FAIL ext_hold_r: got %h expected 7", remainder); end
  endtask

  task automatic test_div_zero();
    int lat;
    launch(8'd45, 4'd0);
    wait_done(lat);
    $display("divzero: 2d / 0 -> q=%h r=%h dz=%b ovf=%b lat=%0d", quotient, remainder, dz, ovf, lat);
`ifdef DIV_ZERO_DETECT_EN
    checks++; if (lat !== 2)           begin errors++; $display("FAIL dz_lat: got %0d expected 2", lat); end
    checks++; if (dz !== 1'b1)         begin errors++; $display("FAIL dz_flag: got %b expected 1", dz); end
    checks++; if (quotient !== 8'hFF)  begin errors++; $display("FAIL dz_q: got %h expected ff", quotient); end
    checks++; if (remainder !== 4'hD)  begin errors++; $display("FAIL dz_r: got %h expected d", remainder); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL dz_ovf: got %b expected 0", ovf); end
`else
    checks++; if (lat !== 10)          begin errors++; $display("FAIL dz_lat: got %0d expected 10", lat); end
    checks++; if (dz !== 1'b0)         begin errors++; $display("FAIL dz_flag: got %b expected 0", dz); end
`endif
  endtask

  task automatic test_handshake();
    int done_cnt = 0;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (done === 1'b1) done_cnt++;
        if (k == 1 || k == 9) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_k%0d: got %b expected 1", k, busy); end
        end
        if (k == 11) begin
          $display("hs op1: 15 / 7 -> q=%h r=%h", quotient, remainder);
          checks++; if (done !== 1'b1)      begin errors++; $display("FAIL hs_done1: got %b expected 1", done); end
          checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL hs_busy_done1: got %b expected 0", busy); end
          checks++; if (quotient !== 8'h03) begin errors++; $display("FAIL hs_q1: got %h expected 03", quotient); end
          checks++; if (remainder !== 4'h0) begin errors++; $display("FAIL hs_r1: got %h expected 0", remainder); end
        end
        if (k == 22) begin
          $display("hs op2: e1 / 6 -> q=%h r=%h", quotient, remainder);
          checks++; if (done !== 1'b1)      begin errors++; $display("FAIL hs_done2: got %b expected 1", done); end
          checks++; if (quotient !== 8'hFB) begin errors++; $display("FAIL hs_q2: got %h expected fb", quotient); end
          checks++; if (remainder !== 4'hF) begin errors++; $display("FAIL hs_r2: got %h expected f", remainder); end
        end
      end
      start = (k < 22);
      if (k == 0) begin
        dividend = 8'd21; divisor = 4'd7;
      end else if (k == 11) begin
        dividend = 8'hE1; divisor = 4'd6;
      end else begin
        dividend = 8'(100 + k); divisor = 4'd5;
      end
    end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL hs_done_count: got %0d expected 2", done_cnt); end
  endtask

  task automatic test_reset_midop();
    int lat;
    int seen = 0;
    launch(8'd21, 4'd7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("midop reset: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
    checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL mid_q: got %h expected 00", quotient); end
    checks++; if (remainder !== 4'h0) begin errors++; $display("FAIL mid_r: got %h expected 0", remainder); end
    checks++; if (ovf !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL mid_flags: got ovf=%b dz=%b expected 0 0", ovf, dz); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", seen); end
    launch(8'd100, 4'd3);
    wait_done(lat);
    $display("after reset: 64 / 3 -> q=%h r=%h lat=%0d", quotient, remainder, lat);
    checks++; if (lat !== 10)          begin errors++; $display("FAIL mid_new_lat: got %0d expected 10", lat); end
    checks++; if (quotient !== 8'd33)  begin errors++; $display("FAIL mid_new_q: got %h expected 21", quotient); end
    checks++; if (remainder !== 4'd1)  begin errors++; $display("FAIL mid_new_r: got %h expected 1", remainder); end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_extremes();
    test_div_zero();
    test_handshake();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_seq_divider.md
SIGNED_SEQ_DIVIDER -- requirements
Module: signed_seq_divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, divisor/remainder width; dividend/quotient width is 2*WIDTH.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port list, in order:
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  start  input  1  request; sampled only when busy=0
  dividend  input  2*WIDTH  signed two's-complement dividend
  divisor  input  WIDTH  signed two's-complement divisor
  busy  output  1  operation in progress
  done  output  1  one-cycle pulse, results valid
  quotient  output  2*WIDTH  signed quotient
  remainder  output  WIDTH  signed remainder
  ovf  output  1  quotient overflow (-2^(2W-1) / -1)
  dz  output  1  divide-by-zero flag (macro-dependent, REQ-018)

Function
REQ-004 The block SHALL compute quotient = dividend/divisor truncated toward zero; remainder = dividend - quotient*divisor, with the dividend's sign (or zero).
REQ-005 The FSM SHALL have the states IDLE, RUN, FIX, DONE.
REQ-006 In IDLE, a start=1 sampled at a rising edge SHALL register the operand magnitudes and sign bits, clear the iteration counter, set busy=1, and move to RUN.
REQ-007 RUN SHALL perform one unsigned restoring-division step per cycle (shift partial remainder left 1, subtract |divisor|, restore if negative, shift quotient bit in) for exactly 2*WIDTH cycles, then go to FIX.
REQ-008 FIX SHALL apply sign correction: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. Results SHALL be registered to quotient/remainder/ovf, then the FSM moves to DONE.
REQ-009 In DONE, done=1 for exactly one cycle; busy=0; the FSM returns to IDLE on the next edge.
REQ-010 Latency: for start sampled at edge N, done SHALL be high in the cycle after edge N+2*WIDTH+2 (cycle after edge N+10 for WIDTH=4); busy SHALL be high from after edge N until after edge N+2*WIDTH+1.
REQ-011 start while busy=1 SHALL be ignored; operand changes while busy SHALL NOT affect the result.
REQ-012 start asserted in the DONE cycle SHALL be ignored; start in IDLE immediately after DONE SHALL be accepted (back-to-back throughput: one result per 2*WIDTH+3 cycles).
REQ-013 quotient, remainder, ovf and dz SHALL hold their values from done until the next done or reset.
REQ-014 ovf SHALL be 1 exactly when dividend = -2^(2W-1) and divisor = -1; quotient SHALL then be -2^(2W-1) (wrapped) and remainder 0.
REQ-015 Internal magnitudes SHALL be 2*WIDTH+1 bits wide so that |-2^(2W-1)| and |-2^(W-1)| are representable without wrap.

Reset
REQ-016 rst=1 at a rising edge SHALL force the FSM to IDLE and set busy, done, ovf, dz to 0 and quotient, remainder to 0, regardless of state, including mid-RUN (the operation is aborted; no done is generated).
REQ-017 rst SHALL take priority over start at the same edge.

Configuration
REQ-018 Macro DIV_ZERO_DETECT_EN: when defined, divisor=0 sampled with start SHALL skip RUN and go directly to FIX; the result is quotient=all ones (-1), remainder=dividend[WIDTH-1:0], dz=1, ovf=0, with done in the cycle after edge N+2. When undefined, dz SHALL be tied to 0, divisor=0 SHALL run the full 2*WIDTH iterations with unchanged latency, and quotient/remainder values SHALL be unspecified.

Verification (WIDTH=4)
REQ-019 Sign quadrants: 21/7 -> q=3,r=0; 21/-7 -> q=-3,r=0; -21/-7 -> q=3,r=0; 30/-6 -> q=-5,r=0; -31/6 -> q=-5,r=-1; done in the cycle after edge N+10.
REQ-020 Extremes: -128/-1 -> q=-128 (8'h80), r=0, ovf=1; -128/1 -> q=-128, ovf=0; 127/-8 -> q=-15, r=7.
REQ-021 Divide by zero, 45/0: with macro, dz=1, q=8'hFF, r=4'hD, done in the cycle after edge N+2; without macro, dz=0 and done in the cycle after edge N+10.
REQ-022 Handshake: start held high continuously with changing operands -> only operands at the accepting edges are used; done pulses exactly one cycle, every 11 cycles.
REQ-023 Reset mid-op: rst asserted 4 cycles after start -> next cycle busy=0, done=0, all outputs 0; no done follows; a new start of 100/3 -> q=33, r=1.
